// File: rtl/boot_image_writer_if.sv
// rtl/boot_image_writer_if.sv - word-stream input and instruction-memory write port of the boot image writer
interface boot_image_writer_if #(
  parameter int MEM_ADDR_W = 14
);
  logic                  wd_valid;
  logic [31:0]           wd_idx;
  logic [31:0]           wd_data;
  logic                  mem_we;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_ready;

  modport master (
    output wd_valid, wd_idx, wd_data, mem_ready,
    input  mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  wd_valid, wd_idx, wd_data, mem_ready,
    output mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/boot_image_writer.sv
// rtl/boot_image_writer.sv - parses header, commits payload to instruction memory, verifies checksum, gates CPU reset
module boot_image_writer #(
  parameter int          MEM_ADDR_W = 14,
  parameter int          MEM_DEPTH  = 16384,
  parameter logic [15:0] MAGIC      = 16'hB007
) (
  input  logic                 clk,
  input  logic                 rst,
  boot_image_writer_if.slave   bus,
  output logic                 cpu_rst,
  output logic                 boot_done,
  output logic [2:0]           boot_err,
  output logic [15:0]          words_loaded
);

  localparam logic [16:0] DEPTH = 17'(MEM_DEPTH);

  typedef enum logic [2:0] {S_HDR, S_LOAD, S_CHECK, S_RUN, S_ERROR} state_t;

  state_t                state_q, state_d;
  logic [31:0]           exp_idx_q, exp_idx_d;
  logic [15:0]           len_q, len_d;
  logic [16:0]           cnt_q, cnt_d;
  logic [31:0]           sum_q, sum_d;
  logic [31:0]           chk_q, chk_d;
  logic                  pend_q, pend_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [15:0]           loaded_q, loaded_d;
  logic [2:0]            err_q, err_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  done_q, done_d;
  logic                  raise;
  logic [2:0]            code;

  always_comb begin
    state_d   = state_q;
    exp_idx_d = exp_idx_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    chk_d     = chk_q;
    pend_d    = pend_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    loaded_d  = loaded_q;
    err_d     = err_q;
    raise     = 1'b0;
    code      = 3'd0;

    // Memory handshake completes independently of whatever the word stream does this cycle.
    if (pend_q && bus.mem_ready) begin
      pend_d   = 1'b0;
      loaded_d = loaded_q + 16'd1;
    end

    unique case (state_q)
      S_HDR: begin
        if (bus.wd_valid) begin
          exp_idx_d = exp_idx_q + 32'd1;
          if (bus.wd_idx != exp_idx_q) begin
            raise = 1'b1;
            code  = 3'd5;
          end else if (bus.wd_data[31:16] != MAGIC) begin
            raise = 1'b1;
            code  = 3'd1;
          end else if ({1'b0, bus.wd_data[15:0]} > DEPTH) begin
            raise = 1'b1;
            code  = 3'd2;
          end else begin
            len_d   = bus.wd_data[15:0];
            cnt_d   = 17'd0;
            sum_d   = 32'd0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (bus.wd_valid) begin
          exp_idx_d = exp_idx_q + 32'd1;
          if (bus.wd_idx != exp_idx_q) begin
            raise = 1'b1;
            code  = 3'd5;
          end else if (cnt_q == {1'b0, len_q}) begin
            chk_d   = bus.wd_data;
            state_d = S_CHECK;
          end else if (pend_q) begin
            // Single-entry buffer still holds the previous word, even if it drains this cycle.
            raise = 1'b1;
            code  = 3'd4;
          end else begin
            pend_d  = 1'b1;
            addr_d  = cnt_q[MEM_ADDR_W-1:0];
            wdata_d = bus.wd_data;
            sum_d   = sum_q + bus.wd_data;
            cnt_d   = cnt_q + 17'd1;
          end
        end
      end
      S_CHECK: begin
        if (bus.wd_valid) begin
          raise = 1'b1;
          code  = 3'd5;
        end else if (!pend_q) begin
          if (chk_q == sum_q) begin
            state_d = S_RUN;
          end else begin
            raise = 1'b1;
            code  = 3'd3;
          end
        end
      end
      default: ;
    endcase

    if (raise) begin
      state_d = S_ERROR;
      err_d   = code;
      pend_d  = 1'b0;
    end

    cpu_rst_d = (state_d != S_RUN);
    done_d    = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_HDR;
      exp_idx_q <= 32'd0;
      len_q     <= 16'd0;
      cnt_q     <= 17'd0;
      sum_q     <= 32'd0;
      chk_q     <= 32'd0;
      pend_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      loaded_q  <= 16'd0;
      err_q     <= 3'd0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_idx_q <= exp_idx_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      chk_q     <= chk_d;
      pend_q    <= pend_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      loaded_q  <= loaded_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
    end
  end

  assign bus.mem_we    = pend_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_rst       = cpu_rst_q;
  assign boot_done     = done_q;
  assign boot_err      = err_q;
  assign words_loaded  = loaded_q;

endmodule

// File: tb/tb_boot_image_writer.sv
// tb/tb_boot_image_writer.sv - directed image loads checked against a protocol-level model and a write scoreboard
module tb_boot_image_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_rst;
  logic        boot_done;
  logic [2:0]  boot_err;
  logic [15:0] words_loaded;

  boot_image_writer_if #(.MEM_ADDR_W(14)) bus ();

  boot_image_writer #(.MEM_ADDR_W(14), .MEM_DEPTH(16384), .MAGIC(16'hB007)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .cpu_rst      (cpu_rst),
    .boot_done    (boot_done),
    .boot_err     (boot_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] img_idx[$];
  logic [31:0] img_dat[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic        saw_we;

  int          m_code, m_loaded, m_evt, m_lat;
  logic        m_run;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Image-level model: the outcome follows from the word list alone when words are spaced and memory is ready.
  task automatic predict();
    logic [31:0] sum;
    int          len;
    bit          done;
    m_code = 0; m_loaded = 0; m_run = 1'b0; m_evt = -1; m_lat = 1;
    sum = 32'd0; len = 0; done = 1'b0;
    exp_addr.delete(); exp_data.delete();
    for (int i = 0; i < img_dat.size(); i++) begin
      if (m_code != 0 || done) break;
      if (img_idx[i] != 32'(i)) begin
        m_code = 5; m_evt = i; m_lat = 1;
      end else if (i == 0) begin
        if (img_dat[i][31:16] != 16'hB007) begin
          m_code = 1; m_evt = i;
        end else if (int'(img_dat[i][15:0]) > 16384) begin
          m_code = 2; m_evt = i;
        end else begin
          len = int'(img_dat[i][15:0]);
        end
      end else if (i - 1 < len) begin
        exp_addr.push_back(32'(i - 1));
        exp_data.push_back(img_dat[i]);
        sum = sum + img_dat[i];
        m_loaded++;
      end else begin
        done   = 1'b1;
        m_evt  = i;
        m_lat  = 2;
        m_code = (img_dat[i] == sum) ? 0 : 3;
        m_run  = (m_code == 0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("invariants", {31'd0, cpu_rst} | {boot_err != 3'd0 && bus.mem_we, boot_done && boot_err != 3'd0, 30'd0},
          {31'd0, ~boot_done});
      if (bus.mem_we) saw_we = 1'b1;
      if (bus.mem_we && bus.mem_ready) begin
        if (exp_addr.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with none expected", bus.mem_addr, bus.mem_wdata);
        end else begin
          chk("write_addr", 32'(bus.mem_addr), exp_addr.pop_front());
          chk("write_data", bus.mem_wdata, exp_data.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.wd_valid = 1'b0;
    exp_addr.delete(); exp_data.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] idx, input logic [31:0] data);
    @(posedge clk); #1;
    bus.wd_valid = 1'b1;
    bus.wd_idx   = idx;
    bus.wd_data  = data;
    @(posedge clk); #1;
    bus.wd_valid = 1'b0;
  endtask

  task automatic seq_idx();
    img_idx.delete();
    for (int i = 0; i < img_dat.size(); i++) img_idx.push_back(32'(i));
  endtask

  task automatic run_image(input string name, input int lit_code, input int lit_loaded);
    do_reset();
    bus.mem_ready = 1'b1;
    predict();
    saw_we = 1'b0;
    chk({name, "_model_code"}, 32'(m_code), 32'(lit_code));
    chk({name, "_model_loaded"}, 32'(m_loaded), 32'(lit_loaded));
    for (int i = 0; i < img_dat.size(); i++) begin
      send_word(img_idx[i], img_dat[i]);
      if (i == m_evt) begin
        @(negedge clk);
        if (m_lat == 2) begin
          chk({name, "_pre_done"}, 32'(boot_done), 32'd0);
          chk({name, "_pre_err"}, 32'(boot_err), 32'd0);
          @(negedge clk);
        end
        chk({name, "_evt_err"}, 32'(boot_err), 32'(m_code));
        chk({name, "_evt_done"}, 32'(boot_done), 32'(m_run));
        chk({name, "_evt_cpu_rst"}, 32'(cpu_rst), 32'(!m_run));
      end
      repeat (3) @(posedge clk);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk({name, "_final_err"}, 32'(boot_err), 32'(m_code));
    chk({name, "_final_done"}, 32'(boot_done), 32'(m_run));
    chk({name, "_final_loaded"}, 32'(words_loaded), 32'(m_loaded));
    chk({name, "_writes_left"}, 32'(exp_addr.size()), 32'd0);
  endtask

  initial begin
    bus.wd_valid  = 1'b0;
    bus.wd_idx    = 32'd0;
    bus.wd_data   = 32'd0;
    bus.mem_ready = 1'b1;
    saw_we        = 1'b0;

    do_reset();
    @(negedge clk);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_boot_done", 32'(boot_done), 32'd0);
    chk("rst_boot_err", 32'(boot_err), 32'd0);
    chk("rst_words_loaded", 32'(words_loaded), 32'd0);

    img_dat = '{32'hB0070003, 32'h11, 32'h22, 32'h33, 32'h66}; seq_idx();
    run_image("good", 0, 3);

    img_dat = '{32'hB0070003, 32'h11, 32'h22, 32'h33, 32'h67}; seq_idx();
    run_image("bad_sum", 3, 3);

    img_dat = '{32'hDEAD0002, 32'h1, 32'h2}; seq_idx();
    run_image("magic", 1, 0);
    chk("magic_no_we", 32'(saw_we), 32'd0);

    img_dat = '{32'hB0074001, 32'h0}; seq_idx();
    run_image("size", 2, 0);

    img_dat = '{32'hB0070000, 32'h0}; seq_idx();
    run_image("empty", 0, 0);

    img_dat = '{32'hB0070003, 32'h11, 32'h22};
    img_idx = '{32'd0, 32'd1, 32'd3};
    run_image("seq", 5, 1);

    // Memory stalled: second payload word lands on an occupied buffer.
    do_reset();
    bus.mem_ready = 1'b0;
    send_word(32'd0, 32'hB0070003);
    repeat (2) @(posedge clk);
    send_word(32'd1, 32'h11);
    @(negedge clk);
    chk("ovf_we_before", 32'(bus.mem_we), 32'd1);
    send_word(32'd2, 32'h22);
    @(negedge clk);
    chk("ovf_err", 32'(boot_err), 32'd4);
    chk("ovf_we_dropped", 32'(bus.mem_we), 32'd0);
    chk("ovf_cpu_rst", 32'(cpu_rst), 32'd1);
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ovf_loaded", 32'(words_loaded), 32'd0);

    // Reset while a write is outstanding.
    do_reset();
    bus.mem_ready = 1'b0;
    send_word(32'd0, 32'hB0070003);
    repeat (2) @(posedge clk);
    send_word(32'd1, 32'hA5A5A5A5);
    @(negedge clk);
    chk("mid_we", 32'(bus.mem_we), 32'd1);
    chk("mid_addr", 32'(bus.mem_addr), 32'd0);
    chk("mid_wdata", bus.mem_wdata, 32'hA5A5A5A5);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("midrst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("midrst_boot_done", 32'(boot_done), 32'd0);
    chk("midrst_boot_err", 32'(boot_err), 32'd0);
    chk("midrst_loaded", 32'(words_loaded), 32'd0);
    rst = 1'b0;
    bus.mem_ready = 1'b1;

    img_dat = '{32'hB0070002, 32'h12345678, 32'hF0000001, 32'h02345679}; seq_idx();
    run_image("after_rst", 0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
